// File: rtl/rave_pkg.sv
// rave_pkg: shared RV32 control-flow encodings.
// Holds the major opcode values the branch unit decodes and the funct3 codes that select the
// conditional-branch comparison. Every control-flow block imports these from here.
package rave_pkg;

  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/bru_resolve.sv
// bru_resolve: combinational branch/jump resolution datapath.
// Evaluates the branch condition, resolves the next PC and the rd link value, and classifies the
// op against the frontend prediction. It holds no state.
// Ports:
//   opcode, branch_type         op decode (major opcode, funct3)
//   rs1, rs2, pc, offset        operands; offset is already sign-extended
//   pred_taken, pred_target     frontend prediction
//   taken, link, mispredict,    resolution flags
//   illegal, misaligned
//   target                      resolved next PC
//   link_data                   rd writeback value
module bru_resolve
  import rave_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [4:0]      opcode,
  input  logic [2:0]      branch_type,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] offset,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] pred_target,
  output logic            taken,
  output logic            link,
  output logic            mispredict,
  output logic            illegal,
  output logic            misaligned,
  output logic [XLEN-1:0] target,
  output logic [XLEN-1:0] link_data
);

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_plus_off;
  logic [XLEN-1:0] jalr_sum;
  logic            cond;
  logic            f3_ok;
  logic            cf_legal;

  // Plain XLEN-bit adders: carries out of the top bit drop, so every address wraps.
  assign pc_plus4    = pc + XLEN'(4);
  assign pc_plus_off = pc + offset;
  assign jalr_sum    = rs1 + offset;

  always_comb begin
    cond  = 1'b0;
    f3_ok = 1'b1;
    unique case (branch_type)
      F3_BEQ:  cond = (rs1 == rs2);
      F3_BNE:  cond = (rs1 != rs2);
      F3_BLT:  cond = ($signed(rs1) < $signed(rs2));
      F3_BGE:  cond = ($signed(rs1) >= $signed(rs2));
      F3_BLTU: cond = (rs1 < rs2);
      F3_BGEU: cond = (rs1 >= rs2);
      default: f3_ok = 1'b0;
    endcase
  end

  always_comb begin
    taken     = 1'b0;
    link      = 1'b0;
    illegal   = 1'b0;
    cf_legal  = 1'b0;
    target    = pc_plus4;
    link_data = '0;
    unique case (opcode)
      OP_BRANCH: begin
        if (f3_ok) begin
          cf_legal = 1'b1;
          taken    = cond;
          if (cond) target = pc_plus_off;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_JAL: begin
        cf_legal  = 1'b1;
        taken     = 1'b1;
        link      = 1'b1;
        target    = pc_plus_off;
        link_data = pc_plus4;
      end
      OP_JALR: begin
        cf_legal  = 1'b1;
        taken     = 1'b1;
        link      = 1'b1;
        target    = {jalr_sum[XLEN-1:1], 1'b0};
        link_data = pc_plus4;
      end
      OP_AUIPC: begin
        // Not control flow: falls through and is never a mispredict.
        link      = 1'b1;
        link_data = pc_plus_off;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign mispredict = cf_legal &&
                      ((taken != pred_taken) || (taken && (target != pred_target)));
  // Only bit 1 matters: bit 0 is either cleared (JALR) or flagged by decode elsewhere.
  assign misaligned = taken && target[1];

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: pipelined branch resolution unit.
// Resolves an op combinationally at issue (bru_resolve) and carries the result through
// PIPE_DEPTH register stages with per-stage valid/ready stall propagation, so results appear
// PIPE_DEPTH cycles after acceptance when the consumer is not stalling.
// Optional feature: define BRU_PERF_CNT_EN to build the saturating mispredict counter;
// otherwise mispredict_cnt is tied to zero and no counter flops exist.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   valid_in / ready_out        issue handshake
//   opcode .. rob_entry_in      op fields, operands, prediction and ROB tag
//   flush                       drop every in-flight op and any op issued this cycle
//   valid_out / ready_in        result handshake
//   rob_entry_out .. link_data  resolved result of the op at the tail stage
//   mispredict_cnt              performance counter
module branch_resolve_unit
  import rave_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ROB_SIZE   = 256,
  parameter int unsigned PIPE_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_in,
  output logic                        ready_out,
  input  logic [4:0]                  opcode,
  input  logic [2:0]                  branch_type,
  input  logic [XLEN-1:0]             rs1,
  input  logic [XLEN-1:0]             rs2,
  input  logic [XLEN-1:0]             pc,
  input  logic [XLEN-1:0]             offset,
  input  logic                        pred_taken,
  input  logic [XLEN-1:0]             pred_target,
  input  logic [$clog2(ROB_SIZE)-1:0] rob_entry_in,
  input  logic                        flush,
  output logic                        valid_out,
  input  logic                        ready_in,
  output logic [$clog2(ROB_SIZE)-1:0] rob_entry_out,
  output logic                        taken,
  output logic                        link,
  output logic                        mispredict,
  output logic                        illegal,
  output logic                        misaligned,
  output logic [XLEN-1:0]             target,
  output logic [XLEN-1:0]             link_data,
  output logic [31:0]                 mispredict_cnt
);

  localparam int unsigned TagW = $clog2(ROB_SIZE);
  localparam int unsigned Last = PIPE_DEPTH - 1;

  if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_depth
    $error("PIPE_DEPTH must be in 1..4");
  end

  typedef struct packed {
    logic [TagW-1:0] rob;
    logic            taken;
    logic            link;
    logic            mispredict;
    logic            illegal;
    logic            misaligned;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link_data;
  } res_t;

  res_t            res_new;
  res_t            stage_q [PIPE_DEPTH];
  logic [Last:0]   valid_q;
  logic [Last:0]   valid_d;
  logic [Last:0]   load;
  logic [Last:0]   adv;
  // room[i]: stage i can take a hand-off from stage i-1; room[PIPE_DEPTH] is the consumer.
  logic [PIPE_DEPTH:1] room;
  logic            accept;

  logic            r_taken;
  logic            r_link;
  logic            r_mispredict;
  logic            r_illegal;
  logic            r_misaligned;
  logic [XLEN-1:0] r_target;
  logic [XLEN-1:0] r_link_data;

  bru_resolve #(
    .XLEN(XLEN)
  ) u_resolve (
    .opcode      (opcode),
    .branch_type (branch_type),
    .rs1         (rs1),
    .rs2         (rs2),
    .pc          (pc),
    .offset      (offset),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .taken       (r_taken),
    .link        (r_link),
    .mispredict  (r_mispredict),
    .illegal     (r_illegal),
    .misaligned  (r_misaligned),
    .target      (r_target),
    .link_data   (r_link_data)
  );

  assign res_new = '{
    rob:        rob_entry_in,
    taken:      r_taken,
    link:       r_link,
    mispredict: r_mispredict,
    illegal:    r_illegal,
    misaligned: r_misaligned,
    target:     r_target,
    link_data:  r_link_data
  };

  // Whenever the tail is empty or draining, every stage ahead of it can shift, so stage 0
  // always has room when this is high.
  assign ready_out = !valid_q[Last] || ready_in;
  assign accept    = valid_in && ready_out && !flush;

  always_comb begin
    room[PIPE_DEPTH] = ready_in;
    for (int i = Last; i >= 1; i--) begin
      adv[i]  = valid_q[i] && room[i+1];
      room[i] = !valid_q[i] || adv[i];
    end
    adv[0] = valid_q[0] && room[1];

    load[0] = accept;
    for (int i = 1; i < PIPE_DEPTH; i++) begin
      load[i] = adv[i-1];
    end

    for (int i = 0; i < PIPE_DEPTH; i++) begin
      valid_d[i] = !flush && (load[i] || (valid_q[i] && !adv[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      if (load[0]) stage_q[0] <= res_new;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        if (load[i]) stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign valid_out     = valid_q[Last];
  assign rob_entry_out = stage_q[Last].rob;
  assign taken         = stage_q[Last].taken;
  assign link          = stage_q[Last].link;
  assign mispredict    = stage_q[Last].mispredict;
  assign illegal       = stage_q[Last].illegal;
  assign misaligned    = stage_q[Last].misaligned;
  assign target        = stage_q[Last].target;
  assign link_data     = stage_q[Last].link_data;

`ifdef BRU_PERF_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (valid_out && ready_in && mispredict && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign mispredict_cnt = cnt_q;
`else
  assign mispredict_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: scoreboard bench for branch_resolve_unit.
// The issue side pushes a reference-model result whenever an op is accepted; an independent
// monitor pops and compares on every output handshake, and also checks output stability while
// stalled and the mispredict counter.
module tb_branch_resolve_unit;

  localparam int unsigned XL = 32;
  localparam int unsigned RS = 256;
  localparam int unsigned PD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic        ready_out;
  logic [4:0]  opcode;
  logic [2:0]  branch_type;
  logic [31:0] rs1, rs2, pc, offset;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [7:0]  rob_entry_in;
  logic        flush;
  logic        valid_out;
  logic        ready_in;
  logic [7:0]  rob_entry_out;
  logic        taken, link, mispredict, illegal, misaligned;
  logic [31:0] target, link_data;
  logic [31:0] mispredict_cnt;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .XLEN       (XL),
    .ROB_SIZE   (RS),
    .PIPE_DEPTH (PD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_in       (valid_in),
    .ready_out      (ready_out),
    .opcode         (opcode),
    .branch_type    (branch_type),
    .rs1            (rs1),
    .rs2            (rs2),
    .pc             (pc),
    .offset         (offset),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .rob_entry_in   (rob_entry_in),
    .flush          (flush),
    .valid_out      (valid_out),
    .ready_in       (ready_in),
    .rob_entry_out  (rob_entry_out),
    .taken          (taken),
    .link           (link),
    .mispredict     (mispredict),
    .illegal        (illegal),
    .misaligned     (misaligned),
    .target         (target),
    .link_data      (link_data),
    .mispredict_cnt (mispredict_cnt)
  );

  typedef struct packed {
    logic [7:0]  tag;
    logic        taken;
    logic        link;
    logic        misp;
    logic        ill;
    logic        mis;
    logic [31:0] target;
    logic [31:0] link_data;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_cnt = 32'd0;
  bit          mon_en = 1'b0;
  int          tag_ctr = 0;

  // Reference model: RISC-V control-flow semantics stated directly in 32-bit arithmetic.
  function automatic exp_t model(input logic [4:0] op, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] p, input logic [31:0] off,
                                 input logic pt, input logic [31:0] ptgt);
    exp_t        e;
    logic        cf;
    logic [31:0] seq, jump;
    seq = p + 32'd4;
    jump = p + off;
    e = '0;
    e.target = seq;
    cf = 1'b0;
    case (op)
      5'b11000: begin
        cf = 1'b1;
        case (f3)
          3'd0: e.taken = (a == b);
          3'd1: e.taken = (a != b);
          3'd4: e.taken = ($signed(a) < $signed(b));
          3'd5: e.taken = !($signed(a) < $signed(b));
          3'd6: e.taken = (a < b);
          3'd7: e.taken = !(a < b);
          default: begin
            cf = 1'b0;
            e.ill = 1'b1;
          end
        endcase
        if (e.taken) e.target = jump;
      end
      5'b11011: begin
        cf = 1'b1; e.taken = 1'b1; e.link = 1'b1; e.target = jump; e.link_data = seq;
      end
      5'b11001: begin
        cf = 1'b1; e.taken = 1'b1; e.link = 1'b1; e.link_data = seq;
        e.target = (a + off) & 32'hFFFF_FFFE;
      end
      5'b00101: begin
        e.link = 1'b1; e.link_data = jump;
      end
      default: e.ill = 1'b1;
    endcase
    e.misp = cf && ((e.taken != pt) || (e.taken && (e.target != ptgt)));
    e.mis = e.taken && e.target[1];
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  // Called just after a negedge with inputs already driven; records an accept, then moves to
  // the next negedge.
  task automatic tick(output bit acc);
    exp_t e;
    #3;
    acc = valid_in && ready_out && !flush && !rst;
    if (acc) begin
      e = model(opcode, branch_type, rs1, rs2, pc, offset, pred_taken, pred_target);
      e.tag = rob_entry_in;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic tick1();
    bit a;
    tick(a);
  endtask

  task automatic set_op(input logic [4:0] op, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] p, input logic [31:0] off,
                        input logic pt, input logic [31:0] ptgt);
    valid_in = 1'b1; opcode = op; branch_type = f3; rs1 = a; rs2 = b; pc = p; offset = off;
    pred_taken = pt; pred_target = ptgt; rob_entry_in = 8'(tag_ctr);
  endtask

  task automatic issue(input string nm);
    bit acc = 1'b0;
    for (int n = 0; n < 50 && !acc; n++) tick(acc);
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL %s: op not accepted within 50 cycles", nm);
    end
    valid_in = 1'b0;
    tag_ctr++;
  endtask

  task automatic wait_out(input string nm);
    for (int n = 0; n < 50 && !valid_out; n++) tick1();
    total++;
    if (!valid_out) begin
      bad++;
      $display("FAIL %s: valid_out low after 50 cycles, want 1", nm);
    end
  endtask

  task automatic rand_op();
    logic [4:0]  op;
    logic [2:0]  f3;
    logic [31:0] a, b, p, off, r;
    logic        pt;
    exp_t        e;
    int          sel;
    sel = $urandom_range(0, 9);
    f3 = 3'($urandom);
    op = (sel <= 5) ? 5'b11000 : (sel == 6) ? 5'b11011 : (sel == 7) ? 5'b11001 :
         (sel == 8) ? 5'b00101 : 5'($urandom);
    case ($urandom_range(0, 2))
      0: begin a = $urandom; b = $urandom; end
      1: begin a = 32'($urandom_range(0, 8)) - 32'd4; b = 32'($urandom_range(0, 8)) - 32'd4; end
      default: begin a = $urandom; b = a; end
    endcase
    p = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(0, 7) == 0) p = 32'hFFFF_FFF0;
    r = $urandom;
    off = {{19{r[12]}}, r[12:0]};
    if ($urandom_range(0, 1) == 0) off[1:0] = 2'b00;
    pt = 1'($urandom);
    e = model(op, f3, a, b, p, off, pt, 32'd0);
    set_op(op, f3, a, b, p, off, pt, ($urandom_range(0, 1) == 0) ? e.target : $urandom);
  endtask

  // Monitor: sampled 1 ns before each rising edge.
  initial begin
    exp_t got, prev, e;
    bit   held;
    held = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      #4;
      if (mon_en) begin
        got = {rob_entry_out, taken, link, mispredict, illegal, misaligned, target, link_data};
        if (held) begin
          total++;
          if (!valid_out || got !== prev) begin
            bad++;
            $display("FAIL hold: valid=%b out=%h, want valid=1 out=%h", valid_out, got, prev);
          end
        end
        if (valid_out && ready_in) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL result: unexpected output tag=%0d, want none", rob_entry_out);
          end else begin
            e = sb.pop_front();
            if (got !== e) begin
              bad++;
              $display("FAIL result: got tag=%0d t=%b l=%b mp=%b il=%b ma=%b tgt=%h ld=%h want tag=%0d t=%b l=%b mp=%b il=%b ma=%b tgt=%h ld=%h",
                       got.tag, got.taken, got.link, got.misp, got.ill, got.mis, got.target,
                       got.link_data, e.tag, e.taken, e.link, e.misp, e.ill, e.mis, e.target,
                       e.link_data);
            end
            chk("perf_cnt", mispredict_cnt, exp_cnt);
`ifdef BRU_PERF_CNT_EN
            if (e.misp && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
`endif
          end
        end
        held = valid_out && !ready_in && !flush && !rst;
        prev = got;
        if (flush || rst) sb.delete();
        if (rst) exp_cnt = 32'd0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int lat, k;
    rst = 1'b1; valid_in = 1'b0; flush = 1'b0; ready_in = 1'b1;
    opcode = '0; branch_type = '0; rs1 = '0; rs2 = '0; pc = '0; offset = '0;
    pred_taken = 1'b0; pred_target = '0; rob_entry_in = '0;
    @(negedge clk);
    tick1();
    tick1();
    rst = 1'b0;
    mon_en = 1'b1;
    chk("rst_valid_out", 32'(valid_out), 0);
    chk("rst_taken", 32'(taken), 0);
    chk("rst_link", 32'(link), 0);
    chk("rst_mispredict", 32'(mispredict), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_misaligned", 32'(misaligned), 0);
    chk("rst_target", target, 0);
    chk("rst_link_data", link_data, 0);
    chk("rst_rob", 32'(rob_entry_out), 0);
    chk("rst_cnt", mispredict_cnt, 0);
    tick1();
    chk("rst_ready_out", 32'(ready_out), 1);

    // BEQ equal, correctly predicted; also measures issue-to-result latency.
    set_op(5'b11000, 3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 32'h120);
    issue("beq");
    lat = 1;
    while (!valid_out && lat < 20) begin
      tick1();
      lat++;
    end
    chk("latency", lat, PD);
    chk("beq_taken", 32'(taken), 1);
    chk("beq_target", target, 32'h120);
    chk("beq_misp", 32'(mispredict), 0);
    tick1();

    set_op(5'b11000, 3'd5, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40, 1'b1, 32'h340);
    issue("bge"); wait_out("bge");
    chk("bge_taken", 32'(taken), 0);
    chk("bge_target", target, 32'h304);
    chk("bge_misp", 32'(mispredict), 1);
    tick1();
    set_op(5'b11000, 3'd7, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40, 1'b1, 32'h340);
    issue("bgeu"); wait_out("bgeu");
    chk("bgeu_taken", 32'(taken), 1);
    chk("bgeu_misp", 32'(mispredict), 0);
    tick1();

    set_op(5'b11001, 3'd0, 32'h1001, 32'd0, 32'h200, 32'd4, 1'b1, 32'h1004);
    issue("jalr"); wait_out("jalr");
    chk("jalr_target", target, 32'h1004);
    chk("jalr_link_data", link_data, 32'h204);
    chk("jalr_link", 32'(link), 1);
    chk("jalr_taken", 32'(taken), 1);
    tick1();

    set_op(5'b11000, 3'd2, 32'd1, 32'd1, 32'h40, 32'h10, 1'b1, 32'h50);
    issue("bad_f3"); wait_out("bad_f3");
    chk("bad_f3_illegal", 32'(illegal), 1);
    chk("bad_f3_taken", 32'(taken), 0);
    tick1();
    set_op(5'b01010, 3'd0, 32'd1, 32'd1, 32'h40, 32'h10, 1'b1, 32'h50);
    issue("bad_op"); wait_out("bad_op");
    chk("bad_op_illegal", 32'(illegal), 1);
    chk("bad_op_target", target, 32'h44);
    chk("bad_op_misp", 32'(mispredict), 0);
    tick1();

    set_op(5'b11011, 3'd0, 32'd0, 32'd0, 32'h400, 32'h22, 1'b1, 32'h400);
    issue("jal_mis"); wait_out("jal_mis");
    chk("jal_misaligned", 32'(misaligned), 1);
    chk("jal_mis_misp", 32'(mispredict), 1);
    tick1();
    set_op(5'b00101, 3'd0, 32'd0, 32'd0, 32'h500, 32'h1000, 1'b1, 32'h504);
    issue("auipc"); wait_out("auipc");
    chk("auipc_link_data", link_data, 32'h1500);
    chk("auipc_taken", 32'(taken), 0);
    chk("auipc_misp", 32'(mispredict), 0);
    tick1();
    set_op(5'b11011, 3'd0, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'h20, 1'b1, 32'h10);
    issue("jal_wrap"); wait_out("jal_wrap");
    chk("jal_wrap_target", target, 32'h10);
    tick1();

    // Four back-to-back ops while the consumer stalls for five cycles.
    k = 0;
    for (int c = 0; c < 30 && (k < 4 || c < 5); c++) begin
      ready_in = (c >= 5);
      if (k < 4) set_op(5'b11000, 3'd1, 32'(k), 32'd9, 32'h800 + 32'(k * 4), 32'h8, 1'b0, 32'h0);
      else valid_in = 1'b0;
      tick(acc);
      if (acc) begin
        k++;
        tag_ctr++;
      end
      if (c == 4) chk("stall_ready_out", 32'(ready_out), 0);
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    chk("b2b_accepted", k, 4);
    for (int n = 0; n < 10; n++) tick1();

    // Flush with two ops held in flight and a third on the input.
    ready_in = 1'b0;
    set_op(5'b11011, 3'd0, 32'd0, 32'd0, 32'h900, 32'h40, 1'b1, 32'h940);
    issue("fl_a");
    set_op(5'b11011, 3'd0, 32'd0, 32'd0, 32'h904, 32'h40, 1'b1, 32'h944);
    issue("fl_b");
    set_op(5'b11011, 3'd0, 32'd0, 32'd0, 32'h908, 32'h40, 1'b1, 32'h948);
    flush = 1'b1;
    tick1();
    flush = 1'b0;
    valid_in = 1'b0;
    chk("flush_valid_out", 32'(valid_out), 0);
    ready_in = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick1();
      chk("flush_no_emit", 32'(valid_out), 0);
    end

    // Reset in the middle of operation.
    ready_in = 1'b0;
    set_op(5'b11000, 3'd0, 32'd3, 32'd3, 32'hA00, 32'h10, 1'b0, 32'h0);
    issue("rst_a");
    set_op(5'b11000, 3'd0, 32'd3, 32'd3, 32'hA04, 32'h10, 1'b0, 32'h0);
    issue("rst_b");
    rst = 1'b1;
    tick1();
    rst = 1'b0;
    chk("midrst_valid_out", 32'(valid_out), 0);
    chk("midrst_target", target, 0);
    chk("midrst_link_data", link_data, 0);
    chk("midrst_cnt", mispredict_cnt, 0);
    chk("midrst_ready_out", 32'(ready_out), 1);
    ready_in = 1'b1;

`ifdef BRU_PERF_CNT_EN
    for (int m = 0; m < 3; m++) begin
      if (m == 2) ready_in = 1'b0;
      set_op(5'b11000, 3'd0, 32'd7, 32'd7, 32'hB00 + 32'(m * 4), 32'h20, 1'b0, 32'h0);
      issue("cnt_op");
      wait_out("cnt_op");
      if (m < 2) tick1();
    end
    tick1();
    tick1();
    chk("cnt_held", mispredict_cnt, 2);
    ready_in = 1'b1;
    tick1();
    chk("cnt_final", mispredict_cnt, 3);
`endif

    for (int c = 0; c < 600; c++) begin
      rand_op();
      valid_in = ($urandom_range(0, 3) != 0);
      ready_in = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 49) == 0);
      tick(acc);
      if (acc) tag_ctr++;
    end
    flush = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    for (int n = 0; n < 40 && sb.size() > 0; n++) tick1();
    tick1();
    chk("drain_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter ROB_SIZE, default 256, ROB entries; tag width $clog2(ROB_SIZE).
REQ-003 SHALL have parameter PIPE_DEPTH, default 2, legal 1..4, result latency in cycles.
REQ-004 SHALL have ports:
clk  in  1  sole clock
rst  in  1  synchronous active-high reset
valid_in  in  1  issue request
ready_out  out  1  unit can accept this cycle
opcode  in  5  11000 branch, 11001 JALR, 11011 JAL, 00101 AUIPC
branch_type  in  3  funct3 of branch
rs1, rs2, pc, offset  in  XLEN each  operands, offset sign-extended
pred_taken  in  1  frontend prediction
pred_target  in  XLEN  frontend predicted target
rob_entry_in  in  $clog2(ROB_SIZE)  ROB tag
flush  in  1  kill all in-flight ops
valid_out  out  1  result valid
ready_in  in  1  consumer accepts result
rob_entry_out  out  $clog2(ROB_SIZE)  tag of result
taken, link, mispredict, illegal, misaligned  out  1 each  resolution flags
target  out  XLEN  resolved next PC
link_data  out  XLEN  rd writeback value
mispredict_cnt  out  32  perf counter (see Configuration)

Function
REQ-005 SHALL accept an op when valid_in && ready_out; ready_out = !stage_full[last] || ready_in (skid-free stall propagation per stage).
REQ-006 SHALL present results exactly PIPE_DEPTH cycles after acceptance when no backpressure occurs.
REQ-007 SHALL hold valid_out and all result outputs stable while valid_out && !ready_in.
REQ-008 SHALL advance each stage independently: a stage loads when it is empty or its downstream stage advances.
REQ-009 SHALL compute branch condition: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; 010/011 SHALL set illegal=1, taken=0.
REQ-010 SHALL produce target: branch taken = pc+offset, not taken = pc+4; JAL = pc+offset; JALR = (rs1+offset) with bit0 cleared; AUIPC = pc+4.
REQ-011 SHALL produce link_data = pc+4 with link=1 for JAL/JALR; pc+offset with link=1 for AUIPC; link=0 for branches.
REQ-012 SHALL set taken=1 for JAL/JALR and taken=0 for AUIPC.
REQ-013 SHALL set illegal=1 for unlisted opcodes, with taken=0, link=0, target=pc+4, mispredict=0.
REQ-014 SHALL set mispredict = (taken != pred_taken) || (taken && target != pred_target), for legal control-flow ops only, never AUIPC.
REQ-015 SHALL set misaligned=1 when taken and target[1]!=0; mispredict still reported.
REQ-016 SHALL wrap all address arithmetic modulo 2^XLEN.
REQ-017 SHALL, on flush, clear every stage valid bit the same cycle; valid_out=0 next cycle; an op presented with flush SHALL be dropped.
REQ-018 SHALL give flush priority over simultaneous accept and advance.

Reset
REQ-019 SHALL, on rst, clear all stage valids, valid_out, taken, link, mispredict, illegal, misaligned, target, link_data, rob_entry_out and mispredict_cnt to 0; ready_out=1 the cycle after reset deasserts.
REQ-020 SHALL treat rst mid-operation as flush plus counter clear.

Configuration
REQ-021 SHALL, with BRU_PERF_CNT_EN defined, increment mispredict_cnt by 1 on each valid_out && ready_in && mispredict handshake, saturating at 32'hFFFFFFFF.
REQ-022 SHALL, without BRU_PERF_CNT_EN, tie mispredict_cnt to 0 and instantiate no counter flops.

Structure
REQ-023 SHALL take opcode constants (OP_BRANCH, OP_JALR, OP_JAL, OP_AUIPC) and funct3 encodings from the shared package rave_pkg.
REQ-024 SHALL implement the comparator/target datapath as combinational sub-module bru_resolve; pipeline registers and handshake live in branch_resolve_unit.

Verification
REQ-025 BEQ rs1=5 rs2=5 pc=0x100 offset=0x20 pred_taken=1 pred_target=0x120 -> after PIPE_DEPTH: taken=1 target=0x120 mispredict=0.
REQ-026 BGE rs1=0xFFFFFFFF rs2=1 pred_taken=1 -> taken=0 target=pc+4 mispredict=1; BGEU same operands -> taken=1.
REQ-027 JALR rs1=0x1001 offset=4 pc=0x200 -> target=0x1004 link_data=0x204 link=1 taken=1.
REQ-028 Back-to-back 4 ops with ready_in=0 for 5 cycles -> ready_out falls after pipe fills, no op lost or duplicated, results in issue order.
REQ-029 flush with two ops in flight plus one on valid_in -> valid_out=0 next cycle, none emitted.
REQ-030 BRU_PERF_CNT_EN defined, 3 mispredicts accepted, one held with ready_in=0 -> mispredict_cnt=3 only after final handshake.
